// File: rtl/stq_adata_rd.sv
// Store-queue address-data drain reader: buffers committed WQ indices in order,
// reads adata through two async table ports and presents up to two results per cycle.
module stq_adata_rd #(
  parameter int DEPTH = 8,
  parameter int WQW   = 6,
  parameter int ADW   = 5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           commit0_en,
  input  logic [WQW-1:0] commit0_WQ,
  input  logic           commit1_en,
  input  logic [WQW-1:0] commit1_WQ,
  output logic           commit_stall,
  input  logic           wrt0_en,
  input  logic [WQW-1:0] wrt0_WQ,
  input  logic [ADW-1:0] wrt0_adata,
  input  logic           wrt1_en,
  input  logic [WQW-1:0] wrt1_WQ,
  input  logic [ADW-1:0] wrt1_adata,
  output logic [WQW-1:0] upd0_WQ,
  input  logic [ADW-1:0] upd0_adata,
  output logic [WQW-1:0] upd1_WQ,
  input  logic [ADW-1:0] upd1_adata,
  output logic           out0_en,
  output logic [WQW-1:0] out0_WQ,
  output logic [ADW-1:0] out0_adata,
  output logic           out1_en,
  output logic [WQW-1:0] out1_WQ,
  output logic [ADW-1:0] out1_adata,
  input  logic           out_ready,
  output logic           ovf
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WQW-1:0] fifo [DEPTH];
  logic [PW-1:0]  rd_ptr, wr_ptr;
  logic [CW-1:0]  count;

  logic           load;
  logic [1:0]     n_pop, n_push;
  logic [CW-1:0]  cnt_after, free, count_nxt;
  logic           push_a, push_b, acc_a, acc_b, drop;
  logic [WQW-1:0] data_a;
  logic [ADW-1:0] fwd0, fwd1;

  assign upd0_WQ      = fifo[rd_ptr];
  assign upd1_WQ      = fifo[rd_ptr + PW'(1)];
  assign commit_stall = (count >= CW'(DEPTH - 1));

  always_comb begin
    load  = !out0_en || out_ready;
    n_pop = 2'd0;
    if (load) begin
      if (count >= CW'(2)) n_pop = 2'd2;
      else                 n_pop = count[1:0];
    end
    cnt_after = count - CW'(n_pop);
    free      = CW'(DEPTH) - cnt_after;

    // A lone commit1 is packed into the first push slot so pushes stay contiguous.
    push_a = commit0_en || commit1_en;
    push_b = commit0_en && commit1_en;
    data_a = commit0_en ? commit0_WQ : commit1_WQ;
    acc_a  = push_a && (free != '0);
    acc_b  = push_b && (free >= CW'(2));
    drop   = (push_a && !acc_a) || (push_b && !acc_b);
    n_push = {1'b0, acc_a} + {1'b0, acc_b};
    count_nxt = cnt_after + CW'(n_push);

    // wrt0 beats wrt1, matching the table's own write priority.
    fwd0 = upd0_adata;
    if (wrt0_en && wrt0_WQ == upd0_WQ)      fwd0 = wrt0_adata;
    else if (wrt1_en && wrt1_WQ == upd0_WQ) fwd0 = wrt1_adata;
    fwd1 = upd1_adata;
    if (wrt0_en && wrt0_WQ == upd1_WQ)      fwd1 = wrt0_adata;
    else if (wrt1_en && wrt1_WQ == upd1_WQ) fwd1 = wrt1_adata;
  end

  always_ff @(posedge clk) begin
    if (acc_a) fifo[wr_ptr]          <= data_a;
    if (acc_b) fifo[wr_ptr + PW'(1)] <= commit1_WQ;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      ovf        <= 1'b0;
      out0_en    <= 1'b0;
      out0_WQ    <= '0;
      out0_adata <= '0;
      out1_en    <= 1'b0;
      out1_WQ    <= '0;
      out1_adata <= '0;
    end else begin
      rd_ptr <= rd_ptr + PW'(n_pop);
      wr_ptr <= wr_ptr + PW'(n_push);
      count  <= count_nxt;
      ovf    <= ovf | drop;
      if (load) begin
        out0_en <= (n_pop != 2'd0);
        out1_en <= (n_pop == 2'd2);
        if (n_pop != 2'd0) begin
          out0_WQ    <= upd0_WQ;
          out0_adata <= fwd0;
        end
        if (n_pop == 2'd2) begin
          out1_WQ    <= upd1_WQ;
          out1_adata <= fwd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_stq_adata_rd.sv
// Directed bench for stq_adata_rd with a behavioural adata table model.
module tb_stq_adata_rd;

  logic       clk = 1'b0;
  logic       rst;
  logic       commit0_en, commit1_en;
  logic [5:0] commit0_WQ, commit1_WQ;
  logic       commit_stall;
  logic       wrt0_en, wrt1_en;
  logic [5:0] wrt0_WQ, wrt1_WQ;
  logic [4:0] wrt0_adata, wrt1_adata;
  logic [5:0] upd0_WQ, upd1_WQ;
  logic [4:0] upd0_adata, upd1_adata;
  logic       out0_en, out1_en;
  logic [5:0] out0_WQ, out1_WQ;
  logic [4:0] out0_adata, out1_adata;
  logic       out_ready;
  logic       ovf;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Table contents: table[i] = i[4:0] ^ 5'h1F (so table[5] = 0x1A).
  function automatic logic [4:0] tbl(input logic [5:0] wq);
    return wq[4:0] ^ 5'h1F;
  endfunction

  assign upd0_adata = tbl(upd0_WQ);
  assign upd1_adata = tbl(upd1_WQ);

  stq_adata_rd #(.DEPTH(8), .WQW(6), .ADW(5)) dut (
    .clk(clk), .rst(rst),
    .commit0_en(commit0_en), .commit0_WQ(commit0_WQ),
    .commit1_en(commit1_en), .commit1_WQ(commit1_WQ),
    .commit_stall(commit_stall),
    .wrt0_en(wrt0_en), .wrt0_WQ(wrt0_WQ), .wrt0_adata(wrt0_adata),
    .wrt1_en(wrt1_en), .wrt1_WQ(wrt1_WQ), .wrt1_adata(wrt1_adata),
    .upd0_WQ(upd0_WQ), .upd0_adata(upd0_adata),
    .upd1_WQ(upd1_WQ), .upd1_adata(upd1_adata),
    .out0_en(out0_en), .out0_WQ(out0_WQ), .out0_adata(out0_adata),
    .out1_en(out1_en), .out1_WQ(out1_WQ), .out1_adata(out1_adata),
    .out_ready(out_ready), .ovf(ovf)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_slots(input string tag, input logic e0, input logic [5:0] w0,
                           input logic e1, input logic [5:0] w1);
    check({tag, ".en0"}, 32'(out0_en), 32'(e0));
    check({tag, ".en1"}, 32'(out1_en), 32'(e1));
    if (e0) begin
      check({tag, ".wq0"}, 32'(out0_WQ), 32'(w0));
      check({tag, ".ad0"}, 32'(out0_adata), 32'(tbl(w0)));
    end
    if (e1) begin
      check({tag, ".wq1"}, 32'(out1_WQ), 32'(w1));
      check({tag, ".ad1"}, 32'(out1_adata), 32'(tbl(w1)));
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic commit(input logic e0, input logic [5:0] w0, input logic e1, input logic [5:0] w1);
    commit0_en = e0; commit0_WQ = w0;
    commit1_en = e1; commit1_WQ = w1;
  endtask

  task automatic chk_reset_outs(input string tag);
    check({tag, ".en0"},   32'(out0_en), 32'(0));
    check({tag, ".en1"},   32'(out1_en), 32'(0));
    check({tag, ".wq0"},   32'(out0_WQ), 32'(0));
    check({tag, ".ad0"},   32'(out0_adata), 32'(0));
    check({tag, ".wq1"},   32'(out1_WQ), 32'(0));
    check({tag, ".ad1"},   32'(out1_adata), 32'(0));
    check({tag, ".stall"}, 32'(commit_stall), 32'(0));
    check({tag, ".ovf"},   32'(ovf), 32'(0));
  endtask

  initial begin
    rst = 1'b0;
    commit(1'b0, 6'd0, 1'b0, 6'd0);
    wrt0_en = 1'b0; wrt0_WQ = '0; wrt0_adata = '0;
    wrt1_en = 1'b0; wrt1_WQ = '0; wrt1_adata = '0;
    out_ready = 1'b0;
    #3;
    chk_reset_outs("reset");
    tick;
    rst = 1'b1;
    tick;

    // Single commit: visible two edges later
    out_ready = 1'b1;
    commit(1'b1, 6'd5, 1'b0, 6'd0);
    tick;
    commit(1'b0, 6'd0, 1'b0, 6'd0);
    chk_slots("single.early", 1'b0, 6'd0, 1'b0, 6'd0);
    tick;
    chk_slots("single", 1'b1, 6'd5, 1'b0, 6'd0);
    check("single.ad_const", 32'(out0_adata), 32'h1A);
    tick;
    chk_slots("single.drain", 1'b0, 6'd0, 1'b0, 6'd0);

    // Pair in one cycle
    commit(1'b1, 6'd3, 1'b1, 6'd9);
    tick;
    commit(1'b0, 6'd0, 1'b0, 6'd0);
    tick;
    chk_slots("pair", 1'b1, 6'd3, 1'b1, 6'd9);
    tick;
    chk_slots("pair.drain", 1'b0, 6'd0, 1'b0, 6'd0);

    // Backpressure and stall
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      commit(1'b1, 6'(20 + 2*k), 1'b1, 6'(21 + 2*k));
      tick;
      if (k >= 1) chk_slots("bp.hold", 1'b1, 6'd20, 1'b1, 6'd21);
      check("bp.stall", 32'(commit_stall), 32'(k == 4));
    end
    commit(1'b0, 6'd0, 1'b0, 6'd0);
    tick;
    chk_slots("bp.hold2", 1'b1, 6'd20, 1'b1, 6'd21);
    check("bp.stall2", 32'(commit_stall), 32'(1));
    check("bp.ovf", 32'(ovf), 32'(0));
    out_ready = 1'b1;
    for (int k = 1; k < 5; k++) begin
      tick;
      chk_slots("bp.drain", 1'b1, 6'(20 + 2*k), 1'b1, 6'(21 + 2*k));
      check("bp.stall_rel", 32'(commit_stall), 32'(0));
    end
    tick;
    chk_slots("bp.empty", 1'b0, 6'd0, 1'b0, 6'd0);
    check("bp.ovf2", 32'(ovf), 32'(0));

    // Forwarding priority: both writes hit, wrt0 wins
    commit(1'b1, 6'd12, 1'b0, 6'd0);
    tick;
    commit(1'b0, 6'd0, 1'b0, 6'd0);
    wrt0_en = 1'b1; wrt0_WQ = 6'd12; wrt0_adata = 5'h04;
    wrt1_en = 1'b1; wrt1_WQ = 6'd12; wrt1_adata = 5'h07;
    tick;
    wrt0_en = 1'b0; wrt1_en = 1'b0;
    check("fwd.both.wq", 32'(out0_WQ), 32'd12);
    check("fwd.both", 32'(out0_adata), 32'h04);
    commit(1'b1, 6'd12, 1'b0, 6'd0);
    tick;
    commit(1'b0, 6'd0, 1'b0, 6'd0);
    wrt1_en = 1'b1; wrt1_WQ = 6'd12; wrt1_adata = 5'h07;
    tick;
    wrt1_en = 1'b0;
    check("fwd.wrt1", 32'(out0_adata), 32'h07);
    // Non-matching writes fall through; writes after the load are not seen
    commit(1'b1, 6'd12, 1'b0, 6'd0);
    tick;
    commit(1'b0, 6'd0, 1'b0, 6'd0);
    wrt0_en = 1'b1; wrt0_WQ = 6'd13; wrt0_adata = 5'h04;
    wrt1_en = 1'b1; wrt1_WQ = 6'd11; wrt1_adata = 5'h07;
    tick;
    check("fwd.miss", 32'(out0_adata), 32'h13);
    out_ready = 1'b0;
    wrt0_WQ = 6'd12; wrt1_en = 1'b0;
    tick;
    wrt0_en = 1'b0;
    check("fwd.late", 32'(out0_adata), 32'h13);
    out_ready = 1'b1;
    tick;
    chk_slots("fwd.empty", 1'b0, 6'd0, 1'b0, 6'd0);

    // Wrap-around: 20 entries through the pointer wrap
    for (int k = 0; k < 10; k++) begin
      commit(1'b1, 6'(40 + 2*k), 1'b1, 6'(41 + 2*k));
      tick;
      if (k >= 1) chk_slots("wrap", 1'b1, 6'(38 + 2*k), 1'b1, 6'(39 + 2*k));
    end
    commit(1'b0, 6'd0, 1'b0, 6'd0);
    tick;
    chk_slots("wrap.last", 1'b1, 6'd58, 1'b1, 6'd59);
    tick;
    chk_slots("wrap.empty", 1'b0, 6'd0, 1'b0, 6'd0);

    // Overflow: fill to 8, then push one more ignoring stall
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      commit(1'b1, 6'(50 + 2*k), 1'b1, 6'(51 + 2*k));
      tick;
    end
    check("ovf.pre", 32'(ovf), 32'(0));
    check("ovf.stall", 32'(commit_stall), 32'(1));
    commit(1'b1, 6'd60, 1'b0, 6'd0);
    tick;
    commit(1'b0, 6'd0, 1'b0, 6'd0);
    check("ovf.set", 32'(ovf), 32'(1));
    chk_slots("ovf.hold", 1'b1, 6'd50, 1'b1, 6'd51);
    out_ready = 1'b1;
    for (int k = 1; k < 5; k++) begin
      tick;
      chk_slots("ovf.drain", 1'b1, 6'(50 + 2*k), 1'b1, 6'(51 + 2*k));
    end
    tick;
    chk_slots("ovf.dropped", 1'b0, 6'd0, 1'b0, 6'd0);
    check("ovf.sticky", 32'(ovf), 32'(1));

    // Reset mid-operation with 5 entries queued
    out_ready = 1'b0;
    commit(1'b1, 6'd1, 1'b1, 6'd2);  tick;
    commit(1'b1, 6'd3, 1'b1, 6'd4);  tick;
    commit(1'b1, 6'd5, 1'b1, 6'd6);  tick;
    commit(1'b1, 6'd8, 1'b0, 6'd0);  tick;
    commit(1'b0, 6'd0, 1'b0, 6'd0);
    chk_slots("rst.pre", 1'b1, 6'd1, 1'b1, 6'd2);
    #2;
    rst = 1'b0;
    #1;
    chk_reset_outs("rst.async");
    tick;
    rst = 1'b1;
    out_ready = 1'b1;
    tick;
    chk_slots("rst.empty", 1'b0, 6'd0, 1'b0, 6'd0);
    commit(1'b1, 6'd7, 1'b0, 6'd0);
    tick;
    commit(1'b0, 6'd0, 1'b0, 6'd0);
    tick;
    chk_slots("rst.fresh", 1'b1, 6'd7, 1'b0, 6'd0);
    check("rst.ovf", 32'(ovf), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
